// File: rtl/cpu10_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu10_pkg
// Description : Shared widths, opcodes, halt encoding and fetch state type
//               for the 10-bit single-cycle-memory CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu10_pkg;

   localparam int INSTR_W = 10;
   localparam int PC_W    = 10;

   // Upper four bits of a word select the operation class.
   localparam logic [3:0] OPC_JUMP = 4'b1000;

   // Encoding that stops fetch unless the instance overrides it.
   localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 10'b0010000010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   // True when the word is a local jump whose target sits in bits [5:0].
   function automatic logic is_jump(input logic [INSTR_W-1:0] word);
      return word[INSTR_W-1:INSTR_W-4] == OPC_JUMP;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Control, ROM and instruction-register signals between the
//               fetch stage (master) and its environment (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
   import cpu10_pkg::*;

   // Control from the rest of the pipeline
   logic               start_i;
   logic               stall_i;
   logic               redirect_valid_i;
   logic [PC_W-1:0]    redirect_pc_i;

   // Instruction ROM, combinational read
   logic [PC_W-1:0]    rom_addr_o;
   logic [INSTR_W-1:0] rom_data_i;

   // Instruction register towards decode/execute
   logic [INSTR_W-1:0] instr_o;
   logic [PC_W-1:0]    instr_pc_o;
   logic               instr_valid_o;
   logic               halted_o;

   modport master (
      input  start_i, stall_i, redirect_valid_i, redirect_pc_i, rom_data_i,
      output rom_addr_o, instr_o, instr_pc_o, instr_valid_o, halted_o
   );

   modport slave (
      output start_i, stall_i, redirect_valid_i, redirect_pc_i, rom_data_i,
      input  rom_addr_o, instr_o, instr_pc_o, instr_valid_o, halted_o
   );

endinterface
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational next-PC selection and halt-word detection.
//               Redirect beats everything; otherwise a local jump (when
//               INSTR_FETCH_JUMP_PREDECODE_EN is defined) or PC+1 with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc
   import cpu10_pkg::*;
#(
   parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  wire logic [PC_W-1:0]    pc,
   input  wire logic [INSTR_W-1:0] word,
   input  wire logic               redirect_valid,
   input  wire logic [PC_W-1:0]    redirect_pc,
   output logic      [PC_W-1:0]    next_pc,
   output logic                    halt_det
);

   logic [PC_W-1:0] w_seq_pc;

   // Sequential successor; the jump target replaces it when pre-decode is on.
   always_comb begin
      w_seq_pc = pc + PC_W'(1);
`ifdef INSTR_FETCH_JUMP_PREDECODE_EN
      if (is_jump(word)) begin
         w_seq_pc = {4'b0000, word[5:0]};
      end
`endif
   end

   // Redirect from execute overrides any locally computed successor.
   always_comb begin
      next_pc  = redirect_valid ? redirect_pc : w_seq_pc;
      halt_det = (word == HALT_WORD);
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage. Owns the PC, addresses the instruction ROM and
//               registers the returned word with its PC. Handles stalls,
//               execute redirects and the halt word.
//               Optional feature macro: INSTR_FETCH_JUMP_PREDECODE_EN
//               (resolve opcode 4'b1000 jumps in fetch with no bubble).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
   import cpu10_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC  = 10'd0,
   parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   instr_fetch_if.master bus
);

   fetch_state_t       r_state, w_state;
   logic [PC_W-1:0]    r_pc, w_pc;
   logic [INSTR_W-1:0] r_instr, w_instr;
   logic [PC_W-1:0]    r_instr_pc, w_instr_pc;
   logic               r_valid, w_valid;
   logic               r_halted, w_halted;

   logic [PC_W-1:0]    w_next_pc;
   logic               w_halt_det;

   fetch_next_pc #(
      .HALT_WORD      (HALT_WORD)
   ) u_next_pc (
      .pc             (r_pc),
      .word           (bus.rom_data_i),
      .redirect_valid (bus.redirect_valid_i),
      .redirect_pc    (bus.redirect_pc_i),
      .next_pc        (w_next_pc),
      .halt_det       (w_halt_det)
   );

   // State and fetch registers; reset clears everything without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_pc       <= w_pc;
         r_instr    <= w_instr;
         r_instr_pc <= w_instr_pc;
         r_valid    <= w_valid;
         r_halted   <= w_halted;
      end
   end

   // Next-state logic: redirect first, then stall hold, then normal fetch.
   always_comb begin
      w_state    = r_state;
      w_pc       = r_pc;
      w_instr    = r_instr;
      w_instr_pc = r_instr_pc;
      w_valid    = r_valid;
      w_halted   = r_halted;

      unique case (r_state)
         ST_IDLE: begin
            w_valid = 1'b0;
            if (bus.start_i) begin
               w_pc    = RESET_PC;
               w_state = ST_RUN;
            end
         end

         ST_RUN: begin
            if (bus.redirect_valid_i) begin
               // The word on the ROM bus is wrong-path: squash it.
               w_pc    = w_next_pc;
               w_valid = 1'b0;
            end else if (!bus.stall_i) begin
               w_instr    = bus.rom_data_i;
               w_instr_pc = r_pc;
               w_valid    = 1'b1;
               if (w_halt_det) begin
                  // Halt word is delivered once; PC parks on its address.
                  w_state  = ST_HALT;
                  w_halted = 1'b1;
               end else begin
                  w_pc = w_next_pc;
               end
            end
         end

         ST_HALT: begin
            w_valid = 1'b0;
            if (bus.redirect_valid_i) begin
               w_pc     = w_next_pc;
               w_state  = ST_RUN;
               w_halted = 1'b0;
            end
         end

         default: begin
            w_state = ST_IDLE;
            w_valid = 1'b0;
         end
      endcase
   end

   assign bus.rom_addr_o    = r_pc;
   assign bus.instr_o       = r_instr;
   assign bus.instr_pc_o    = r_instr_pc;
   assign bus.instr_valid_o = r_valid;
   assign bus.halted_o      = r_halted;

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 10-bit single-cycle-memory CPU. Owns the program counter and drives the instruction ROM's combinational read address. Registers the returned 10-bit word into an instruction register for decode/execute. Handles sequential increment, local jump pre-decode, redirects from execute (taken `beq`), stalls, and the halt word.

## Interface
Parameters:
- `RESET_PC`, default 10'd0: PC value after reset and on `start_i`.
- `HALT_WORD`, default 10'b0010000010: encoding that stops fetch.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  one-cycle pulse; leaves IDLE and begins fetching at `RESET_PC`.
- `stall_i`  in  1  downstream not ready; hold all fetch state.
- `redirect_valid_i`  in  1  execute resolved a taken branch or jump.
- `redirect_pc_i`  in  10  new PC for the redirect.
- `rom_addr_o`  out  10  ROM read address; equals the PC register.
- `rom_data_i`  in  10  ROM read data, combinational from `rom_addr_o`.
- `instr_o`  out  10  registered instruction word.
- `instr_pc_o`  out  10  PC of the word in `instr_o`.
- `instr_valid_o`  out  1  `instr_o` holds a live instruction.
- `halted_o`  out  1  fetch is stopped on `HALT_WORD`.

## Operation
- States: IDLE, RUN, HALT.
  - IDLE → RUN on `start_i`; PC ← `RESET_PC`.
  - RUN → HALT when `rom_data_i == HALT_WORD` is latched.
  - HALT → RUN on `redirect_valid_i`.
  - HALT is otherwise left only by reset.
- RUN cycle with `stall_i=0` and no redirect:
  - `instr_o` ← `rom_data_i`.
  - `instr_pc_o` ← PC.
  - `instr_valid_o` ← 1.
  - PC ← next PC.
- Next PC: if the fetched word has opcode `[9:6]==4'b1000` (jump), next PC is `{4'b0, rom_data_i[5:0]}`. Otherwise it is PC+1, 10-bit wrap (1023 → 0).
- Redirect has priority over everything, including stall:
  - PC ← `redirect_pc_i`.
  - `instr_valid_o` ← 0 (squash the wrong-path word).
  - State ← RUN.
- Stall without redirect: PC, `instr_o`, `instr_pc_o` and `instr_valid_o` all hold.
- Halt word fetched:
  - It is latched with `instr_valid_o=1` for one cycle; `halted_o` ← 1.
  - PC holds at the halt address.
  - From the following cycle `instr_valid_o=0`.
- Redirect in the same cycle the halt word is read: the redirect wins, nothing is latched and no halt occurs.
- `start_i` outside IDLE is ignored.
- IDLE: `instr_valid_o=0`, PC holds.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state = IDLE.
  - PC = `RESET_PC`.
  - `instr_o` = 0.
  - `instr_pc_o` = 0.
  - `instr_valid_o` = 0.
  - `halted_o` = 0.
- Latency: the word at address A appears on `instr_o` one clock edge after PC = A.
- Throughput: one instruction per cycle when not stalled.
- Jump pre-decode costs zero bubbles.
- A redirect costs one bubble: `instr_valid_o=0` for one cycle, then the target word appears.
- Reset asserted mid-operation aborts immediately; no partial state survives.

## Configuration
- `INSTR_FETCH_JUMP_PREDECODE_EN` defined:
  - Jump opcode 4'b1000 is resolved in fetch, as described above.
  - The jump word is still passed downstream with `instr_valid_o=1`; execute must not redirect again.
- Undefined:
  - Next PC is always PC+1, apart from redirects.
  - Jumps are resolved by execute through `redirect_valid_i`, costing one bubble.

## Structure
- Shared package `cpu10_pkg`:
  - `INSTR_W=10`, `PC_W=10`.
  - `OPC_JUMP=4'b1000`.
  - `HALT_WORD` default.
  - Fetch state enum {IDLE, RUN, HALT}.
- One sub-module, `fetch_next_pc`:
  - Combinational.
  - Inputs: PC, fetched word, redirect.
  - Outputs: next PC and a halt-detect flag.
  - Contains the `INSTR_FETCH_JUMP_PREDECODE_EN` guard.

## Test plan
- Reset, then `start_i`, with ROM holding sequential non-jump words → `rom_addr_o` 0,1,2,3 on consecutive cycles; `instr_pc_o` trails by one; `instr_valid_o=1` continuously.
- Word 10'b1000000111 at address 5 (macro on) → next `rom_addr_o`=7, no bubble. Macro off → `rom_addr_o`=6; a redirect to 7 yields one cycle with `instr_valid_o=0`.
- `stall_i`=1 for 3 cycles at PC=12 → `rom_addr_o`, `instr_o` and `instr_pc_o` frozen; resumes at 13 after release.
- `redirect_valid_i`=1 with `redirect_pc_i`=21 while `stall_i`=1 → `rom_addr_o`=21 next cycle, `instr_valid_o`=0 one cycle, then `instr_pc_o`=21.
- HALT_WORD at address 26 → `instr_o`=10'b0010000010 valid one cycle; `halted_o`=1; `rom_addr_o` stays 26; `instr_valid_o`=0 thereafter. A redirect to 0 restarts fetch.
- Reset asserted mid-run at PC=300 → all outputs zero and `rom_addr_o`=`RESET_PC` immediately, without a clock edge; PC=1023 with no jump wraps to 0.
